color_nav_core: RTL and testbench

COLOR_NAV_CORE -- requirements
Module: color_nav_core

---
 rtl/color_nav_core_pkg.sv | 26 ++
 rtl/nav_pwm.sv | 42 ++++
 rtl/color_nav_core.sv | 195 +++++++++++++++++++
 tb/tb_color_nav_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_nav_core_pkg.sv
// rtl/color_nav_core_pkg.sv - shared state/colour encodings and default thresholds
package color_nav_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_TURN_L = 3'd2,
        ST_TURN_R = 3'd3,
        ST_ROT    = 3'd4,
        ST_STOP   = 3'd5
    } nav_state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RED    = 3'd1,
        CLS_GREEN  = 3'd2,
        CLS_BLUE   = 3'd3,
        CLS_PURPLE = 3'd4,
        CLS_YELLOW = 3'd5
    } color_cls_t;

    localparam logic [7:0] DEF_TH_HI = 8'h96;
    localparam logic [7:0] DEF_TH_LO = 8'h32;
    localparam int         DEF_DEB   = 4;

endpackage

// File: rtl/nav_pwm.sv
// rtl/nav_pwm.sv - one motor drive: free-running counter, period-boundary duty/dir latch, comparator
module nav_pwm #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] duty,
    input  logic          dir_tgt,
    output logic          pwm,
    output logic          dir
);

    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_n;
    logic [PW-1:0] duty_q;
    logic [PW-1:0] duty_n;
    logic          wrap;

    // pwm is registered from next-cycle values so it always equals (cnt < duty_q)
    always_comb begin
        cnt_n  = cnt + 1'b1;
        wrap   = (cnt_n == '0);
        duty_n = wrap ? duty : duty_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            duty_q <= '0;
            pwm    <= 1'b0;
            dir    <= 1'b1;
        end else begin
            cnt    <= cnt_n;
            duty_q <= duty_n;
            pwm    <= (cnt_n < duty_n);
            if (wrap) begin
                dir <= dir_tgt;
            end
        end
    end

endmodule

// File: rtl/color_nav_core.sv
// rtl/color_nav_core.sv - colour navigation: classifier, debouncer, manoeuvre FSM/timer, two PWM drives
module color_nav_core
    import color_nav_core_pkg::*;
#(
    parameter int            CW    = 8,
    parameter logic [CW-1:0] TH_HI = CW'(DEF_TH_HI),
    parameter logic [CW-1:0] TH_LO = CW'(DEF_TH_LO),
    parameter int            DEB   = DEF_DEB,
    parameter int            TW    = 6,
    parameter int            PW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    input  logic [TW-1:0] turn_len,
    input  logic [TW-1:0] rot_len,
    input  logic [PW-1:0] duty_fwd,
    input  logic [PW-1:0] duty_turn,
    output logic          motor_l,
    output logic          motor_r,
    output logic          dir_l,
    output logic          dir_r,
    output logic [2:0]    state_code
);

    localparam int DW = $clog2(DEB + 1);

    color_cls_t    cls;
    color_cls_t    cand;
    color_cls_t    last_cls;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_next;
    logic          accept_set;
    logic          accept;

    nav_state_t    state;
    nav_state_t    state_n;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_n;
    logic [TW-1:0] turn_ld;
    logic [TW-1:0] rot_ld;
    logic          done;

    logic [PW-1:0] duty_l_tgt;
    logic [PW-1:0] duty_r_tgt;
    logic          dir_l_tgt;
    logic          dir_r_tgt;

    logic r_hi, g_hi, b_hi, r_lo, g_lo, b_lo;

    assign r_hi = (r >= TH_HI);
    assign g_hi = (g >= TH_HI);
    assign b_hi = (b >= TH_HI);
    assign r_lo = (r < TH_LO);
    assign g_lo = (g < TH_LO);
    assign b_lo = (b < TH_LO);

    always_comb begin
        cls = CLS_NONE;
        if (r_hi && g_lo && b_lo)      cls = CLS_RED;
        else if (g_hi && r_lo && b_lo) cls = CLS_GREEN;
        else if (b_hi && r_lo && g_lo) cls = CLS_BLUE;
        else if (r_hi && g_hi && b_lo) cls = CLS_YELLOW;
        else if (r_hi && b_hi && g_lo) cls = CLS_PURPLE;
    end

    // run length of the current class, saturating at DEB; none clears it
    always_comb begin
        deb_next = '0;
        if (cls != CLS_NONE) begin
            if (cls != cand)              deb_next = DW'(1);
            else if (deb_cnt >= DW'(DEB)) deb_next = deb_cnt;
            else                          deb_next = deb_cnt + 1'b1;
        end
    end

    assign accept_set = (cls != CLS_NONE) && (deb_next == DW'(DEB)) && (cls != last_cls);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand     <= CLS_NONE;
            deb_cnt  <= '0;
            last_cls <= CLS_NONE;
            accept   <= 1'b0;
        end else begin
            cand    <= cls;
            deb_cnt <= deb_next;
            accept  <= accept_set;
            if (accept_set) begin
                last_cls <= cls;
            end
        end
    end

    assign turn_ld = (turn_len == '0) ? TW'(1) : turn_len;
    assign rot_ld  = (rot_len == '0)  ? TW'(1) : rot_len;
    assign done    = (tmr == TW'(1));

    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        if (!run) begin
            state_n = ST_IDLE;
            tmr_n   = '0;
        end else begin
            case (state)
                ST_IDLE: state_n = ST_FWD;
                ST_FWD, ST_STOP: begin
                    if (accept) begin
                        case (last_cls)
                            CLS_GREEN:  state_n = ST_FWD;
                            CLS_RED:    state_n = ST_STOP;
                            CLS_BLUE: begin
                                state_n = ST_TURN_L;
                                tmr_n   = turn_ld;
                            end
                            CLS_YELLOW: begin
                                state_n = ST_TURN_R;
                                tmr_n   = turn_ld;
                            end
                            CLS_PURPLE: begin
                                state_n = ST_ROT;
                                tmr_n   = rot_ld;
                            end
                            default: state_n = state;
                        endcase
                    end
                end
                ST_TURN_L, ST_TURN_R, ST_ROT: begin
                    // accept pulses are ignored here; done always returns to FWD
                    tmr_n = tmr - 1'b1;
                    if (done) begin
                        state_n = ST_FWD;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
        end
    end

    assign state_code = state;

    always_comb begin
        duty_l_tgt = '0;
        duty_r_tgt = '0;
        dir_l_tgt  = 1'b1;
        dir_r_tgt  = 1'b1;
        case (state)
            ST_FWD: begin
                duty_l_tgt = duty_fwd;
                duty_r_tgt = duty_fwd;
            end
            ST_TURN_L: duty_r_tgt = duty_turn;
            ST_TURN_R: duty_l_tgt = duty_turn;
            ST_ROT: begin
                duty_l_tgt = duty_turn;
                duty_r_tgt = duty_turn;
                dir_l_tgt  = 1'b0;
            end
            default: ;
        endcase
    end

    nav_pwm #(.PW(PW)) u_pwm_l (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty_l_tgt),
        .dir_tgt (dir_l_tgt),
        .pwm     (motor_l),
        .dir     (dir_l)
    );

    nav_pwm #(.PW(PW)) u_pwm_r (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty_r_tgt),
        .dir_tgt (dir_r_tgt),
        .pwm     (motor_r),
        .dir     (dir_r)
    );

endmodule

// File: tb/tb_color_nav_core.sv
// tb/tb_color_nav_core.sv - directed scenarios plus random colour streams against a behavioural model
module tb_color_nav_core;

    localparam int TH_HI = 150;
    localparam int TH_LO = 50;
    localparam int DEB   = 4;
    localparam int C_NONE = 0, C_RED = 1, C_GREEN = 2, C_BLUE = 3, C_PURPLE = 4, C_YELLOW = 5;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] r, g, b;
    logic [5:0] turn_len, rot_len;
    logic [7:0] duty_fwd, duty_turn;
    logic       motor_l, motor_r, dir_l, dir_r;
    logic [2:0] state_code;

    color_nav_core dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .r          (r),
        .g          (g),
        .b          (b),
        .turn_len   (turn_len),
        .rot_len    (rot_len),
        .duty_fwd   (duty_fwd),
        .duty_turn  (duty_turn),
        .motor_l    (motor_l),
        .motor_r    (motor_r),
        .dir_l      (dir_l),
        .dir_r      (dir_r),
        .state_code (state_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int m_state, m_rem, m_last, m_cnt, m_dl, m_dr;
    bit m_acc, m_dirl, m_dirr;
    int hist[$];
    int n, cl, cr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int classify(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        bit rh, gh, bh, rl, gl, bl;
        rh = rr >= TH_HI; gh = gg >= TH_HI; bh = bb >= TH_HI;
        rl = rr < TH_LO;  gl = gg < TH_LO;  bl = bb < TH_LO;
        if (rh && gl && bl) return C_RED;
        if (gh && rl && bl) return C_GREEN;
        if (bh && rl && gl) return C_BLUE;
        if (rh && gh && bl) return C_YELLOW;
        if (rh && bh && gl) return C_PURPLE;
        return C_NONE;
    endfunction

    task automatic model_reset();
        m_state = 0; m_rem = 0; m_last = C_NONE; m_acc = 0;
        m_cnt = 0; m_dl = 0; m_dr = 0; m_dirl = 1; m_dirr = 1;
        hist.delete();
    endtask

    // one rising edge of the reference: PWM period bookkeeping, navigation rules, debounce window
    task automatic model_step();
        int cls, tdl, tdr, ns;
        bit tdirl, tdirr, acc_new;
        cls = classify(r, g, b);
        tdl = 0; tdr = 0; tdirl = 1; tdirr = 1;
        case (m_state)
            1: begin tdl = duty_fwd; tdr = duty_fwd; end
            2: tdr = duty_turn;
            3: tdl = duty_turn;
            4: begin tdl = duty_turn; tdr = duty_turn; tdirl = 0; end
            default: ;
        endcase
        m_cnt = (m_cnt + 1) % 256;
        if (m_cnt == 0) begin
            m_dl = tdl; m_dr = tdr; m_dirl = tdirl; m_dirr = tdirr;
        end
        ns = m_state;
        if (!run) begin
            ns = 0; m_rem = 0;
        end else if (m_state == 0) begin
            ns = 1;
        end else if (m_state == 1 || m_state == 5) begin
            if (m_acc) begin
                case (m_last)
                    C_GREEN:  ns = 1;
                    C_RED:    ns = 5;
                    C_BLUE:   begin ns = 2; m_rem = (turn_len == 0) ? 1 : int'(turn_len); end
                    C_YELLOW: begin ns = 3; m_rem = (turn_len == 0) ? 1 : int'(turn_len); end
                    C_PURPLE: begin ns = 4; m_rem = (rot_len == 0) ? 1 : int'(rot_len); end
                    default:  ;
                endcase
            end
        end else begin
            m_rem--;
            if (m_rem == 0) ns = 1;
        end
        m_state = ns;
        hist.push_back(cls);
        if (hist.size() > DEB) void'(hist.pop_front());
        acc_new = (cls != C_NONE) && (hist.size() == DEB) && (cls != m_last);
        foreach (hist[i]) if (hist[i] != cls) acc_new = 0;
        if (acc_new) m_last = cls;
        m_acc = acc_new;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("state", state_code, m_state);
        check("motor_l", motor_l, (m_cnt < m_dl));
        check("motor_r", motor_r, (m_cnt < m_dr));
        check("dir_l", dir_l, m_dirl);
        check("dir_r", dir_r, m_dirr);
    endtask

    function automatic logic [7:0] hi();
        return 8'($urandom_range(255, TH_HI));
    endfunction
    function automatic logic [7:0] lo();
        return 8'($urandom_range(TH_LO - 1, 0));
    endfunction
    function automatic logic [7:0] mid();
        return 8'($urandom_range(TH_HI - 1, TH_LO));
    endfunction

    task automatic set_col(input int c);
        r = mid(); g = mid(); b = mid();
        case (c)
            C_RED:    begin r = hi(); g = lo(); b = lo(); end
            C_GREEN:  begin r = lo(); g = hi(); b = lo(); end
            C_BLUE:   begin r = lo(); g = lo(); b = hi(); end
            C_YELLOW: begin r = hi(); g = hi(); b = lo(); end
            C_PURPLE: begin r = hi(); g = lo(); b = hi(); end
            default:  ;
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_code, 0);
        check({tag, "_motor_l"}, motor_l, 0);
        check({tag, "_motor_r"}, motor_r, 0);
        check({tag, "_dir_l"}, dir_l, 1);
        check({tag, "_dir_r"}, dir_r, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; run = 1'b0;
        r = 8'h00; g = 8'h00; b = 8'h00;
        turn_len = 6'd5; rot_len = 6'd0;
        duty_fwd = 8'h80; duty_turn = 8'h40;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // green held with run asserted; 50% duty over one full period
        rst = 1'b1; run = 1'b1;
        r = 8'h10; g = 8'hA0; b = 8'h10;
        cycle();
        check("run_to_fwd", state_code, 1);
        repeat (4) cycle();
        for (int k = 0; k < 300 && m_cnt != 0; k++) cycle();
        check("wrap_reached_1", m_cnt, 0);
        cl = 0; cr = 0;
        for (int k = 0; k < 256; k++) begin
            cl += int'(motor_l); cr += int'(motor_r);
            cycle();
        end
        check("fwd_high_l", cl, 128);
        check("fwd_high_r", cr, 128);

        // blue -> TURN_L for turn_len cycles; a one-cycle red glitch is ignored
        turn_len = 6'd5;
        set_col(C_BLUE);
        for (int k = 0; k < 12 && state_code != 3'd2; k++) cycle();
        check("turn_l_entry", state_code, 2);
        n = 0;
        for (int k = 0; k < 20 && state_code == 3'd2; k++) begin
            n++;
            if (k == 2) set_col(C_RED);
            if (k == 3) set_col(C_NONE);
            cycle();
        end
        check("turn_l_cycles", n, 5);
        check("turn_l_exit", state_code, 1);

        // purple with rot_len=0, timed so the single ROT cycle sits on a period boundary
        rot_len = 6'd0;
        for (int k = 0; k < 300 && m_cnt != 250; k++) cycle();
        check("align_rot", m_cnt, 250);
        set_col(C_PURPLE);
        repeat (5) cycle();
        check("rot_entry", state_code, 4);
        cycle();
        check("rot_one_cycle", state_code, 1);
        check("rot_dir_l", dir_l, 0);
        check("rot_dir_r", dir_r, 1);
        set_col(C_NONE);

        // red/none toggling every 2 cycles never settles long enough to accept
        for (int k = 0; k < 24; k++) begin
            set_col(((k / 2) % 2) ? C_NONE : C_RED);
            cycle();
            check("toggle_stays_fwd", state_code, 1);
        end

        // run dropped mid-ROT
        set_col(C_GREEN);
        repeat (6) cycle();
        rot_len = 6'd40;
        set_col(C_PURPLE);
        for (int k = 0; k < 12 && state_code != 3'd4; k++) cycle();
        check("rot_long_entry", state_code, 4);
        repeat (3) cycle();
        run = 1'b0;
        cycle();
        check("run_drop_idle", state_code, 0);
        for (int k = 0; k < 300 && m_cnt != 0; k++) cycle();
        check("wrap_reached_2", m_cnt, 0);
        cl = 0;
        for (int k = 0; k < 256; k++) begin
            cl += int'(motor_l) + int'(motor_r);
            cycle();
        end
        check("idle_motors_off", cl, 0);

        // asynchronous reset mid-TURN_R
        run = 1'b1;
        turn_len = 6'd20;
        set_col(C_YELLOW);
        for (int k = 0; k < 12 && state_code != 3'd3; k++) cycle();
        check("turn_r_entry", state_code, 3);
        repeat (3) cycle();
        #2 rst = 1'b0;
        model_reset();
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        set_col(C_NONE);

        // random colour streams, lengths, duties and run drops
        for (int seg = 0; seg < 400; seg++) begin
            run = ($urandom_range(19, 0) != 0);
            if ($urandom_range(9, 0) == 0) begin
                turn_len  = 6'($urandom_range(12, 0));
                rot_len   = 6'($urandom_range(12, 0));
                duty_fwd  = 8'($urandom);
                duty_turn = 8'($urandom);
            end
            if ($urandom_range(3, 0) == 0) begin
                r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            end else begin
                set_col($urandom_range(5, 0));
            end
            repeat ($urandom_range(8, 1)) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
